// File: rtl/hydra_sram_pkg.sv
// Shared constants and types for the packet buffer SRAM read path.
package hydra_sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 14;
   localparam int unsigned SRAM_DATA_W = 16;

   typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
   typedef logic [SRAM_DATA_W-1:0] sram_data_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO of {last, data} that absorbs the SRAM read latency.
module rd_skid_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              push_last,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              head_valid,
   output logic              head_last,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_valid             = (count != '0);
   assign do_pop                 = pop && head_valid;
   assign {head_last, head_data} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {push_last, push_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/sram_pkt_reader.sv
// Packet read sequencer: issues credit-limited SRAM reads for a descriptor and
// streams the words out on valid/ready with last-word marking.
module sram_pkt_reader
   import hydra_sram_pkg::*;
#(
   parameter int unsigned ADDR_W = SRAM_ADDR_W,
   parameter int unsigned DATA_W = SRAM_DATA_W,
   parameter int unsigned LEN_W  = 7,
   parameter int unsigned DEPTH  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   rd_state_t         state;
   rd_state_t         state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  remain;
   logic              inflight;
   logic              inflight_last;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    used;
   logic              credit_ok;
   logic              is_final;
   logic              accept;
   logic              pop;
   logic              drain_done;
   logic              head_valid;
   logic              head_last;
   logic [DATA_W-1:0] head_data;

   assign used      = {1'b0, count} + (CNT_W + 1)'(inflight);
   assign credit_ok = used < (CNT_W + 1)'(DEPTH);
   assign is_final  = (remain == LEN_W'(1));
   assign accept    = (state == IDLE) && req_valid;
   assign pop       = out_valid && out_ready;
   // Done once the word being handed off now is the only one left.
   assign drain_done = !inflight && (count == CNT_W'(pop));

   assign rd_addr   = cur_addr;
   assign busy      = (state != IDLE);
   assign out_valid = head_valid;
   assign out_data  = head_valid ? head_data : '0;
   assign out_last  = head_valid && head_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rd_en     = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = (req_len == '0) ? DRAIN : READ;
            end
         end
         READ: begin
            rd_en = credit_ok;
            if (credit_ok && is_final) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr      <= '0;
         remain        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= rd_en;
         inflight_last <= rd_en && is_final;
         if (accept) begin
            cur_addr <= req_addr;
            remain   <= req_len;
         end else if (rd_en) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            remain   <= remain - LEN_W'(1);
         end
      end
   end

   rd_skid_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (inflight),
      .push_last  (inflight_last),
      .push_data  (rd_data),
      .pop        (pop),
      .head_valid (head_valid),
      .head_last  (head_last),
      .head_data  (head_data),
      .count      (count)
   );

endmodule

// File: tb/tb_sram_pkt_reader.sv
// Directed bench for sram_pkt_reader with an SRAM model and output scoreboard.
module tb_sram_pkt_reader;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [13:0] req_addr  = '0;
   logic [6:0]  req_len   = '0;
   logic        rd_en;
   logic [13:0] rd_addr;
   logic [15:0] rd_data   = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [13:0] addr_q [$];
   logic [16:0] exp_q  [$];

   int outstanding = 0;
   int first_rd    = -1;
   int first_out   = -1;
   int last_out    = -1;
   int out_words   = 0;

   logic        prev_stall = 1'b0;
   logic        prev_last  = 1'b0;
   logic [15:0] prev_data  = '0;

   sram_pkt_reader #(
      .ADDR_W (14),
      .DATA_W (16),
      .LEN_W  (7),
      .DEPTH  (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Preloaded SRAM contents: a distinct word per address.
   function automatic logic [15:0] sram_word(input logic [13:0] a);
      return {a[1:0], a} ^ 16'hA5C3;
   endfunction

   always @(posedge clk) begin
      if (rd_en) rd_data <= sram_word(rd_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output/read monitor: checks addresses, words, credits and stall stability.
   always @(negedge clk) begin
      logic [13:0] ea;
      logic [16:0] ew;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_last, prev_data}));
         if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            outstanding++;
            ea = (addr_q.size() != 0) ? addr_q.pop_front() : ~rd_addr;
            chk("rd_addr", 32'(rd_addr), 32'(ea));
            chk("credit_limit", 32'(outstanding <= 3), 32'd1);
         end
         if (out_valid && out_ready) begin
            out_words++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            outstanding--;
            ew = (exp_q.size() != 0) ? exp_q.pop_front() : ~{out_last, out_data};
            chk("out_word", 32'({out_last, out_data}), 32'(ew));
         end
         prev_stall = out_valid && !out_ready;
         prev_last  = out_last;
         prev_data  = out_data;
      end
   end

   task automatic clear_stats();
      first_rd  = -1;
      first_out = -1;
      last_out  = -1;
      out_words = 0;
   endtask

   // Called just after a rising edge; returns the cycle index ending in the accept edge.
   task automatic send_req(input logic [13:0] a, input int n, output int e0);
      req_valid = 1'b1;
      req_addr  = a;
      req_len   = 7'(n);
      for (int k = 0; k < n; k++) begin
         addr_q.push_back(a + 14'(k));
         exp_q.push_back({k == n - 1, sram_word(a + 14'(k))});
      end
      e0 = -1;
      for (int t = 0; t < 20 && e0 < 0; t++) begin
         @(negedge clk);
         if (req_ready) e0 = cyc;
      end
      chk("req_accept", 32'(e0 >= 0), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 14'h2AAA;
      req_len   = 7'h55;
   endtask

   task automatic wait_idle(output int idle);
      idle = -1;
      for (int t = 0; t < 400 && idle < 0; t++) begin
         @(negedge clk);
         if (req_ready) idle = cyc;
      end
      #1;
      chk("idle_reached", 32'(idle >= 0), 32'd1);
      chk("queues_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);
   endtask

   task automatic run_stream(input logic [13:0] a, input int n, input string tag);
      int e0;
      int idle;
      clear_stats();
      out_ready = 1'b1;
      send_req(a, n, e0);
      wait_idle(idle);
      chk({tag, "_first_rd"},  32'(first_rd),  32'((n > 0) ? e0 + 1 : -1));
      chk({tag, "_first_out"}, 32'(first_out), 32'((n > 0) ? e0 + 3 : -1));
      chk({tag, "_last_out"},  32'(last_out),  32'((n > 0) ? e0 + n + 2 : -1));
      chk({tag, "_idle_cyc"},  32'(idle),      32'((n > 0) ? e0 + n + 3 : e0 + 2));
      chk({tag, "_words"},     32'(out_words), 32'(n));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e0;
      int idle;
      int got3;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rd_en",     32'(rd_en),     32'd0);
      chk("rst_rd_addr",   32'(rd_addr),   32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      @(posedge clk);
      #1;

      run_stream(14'h0100, 4, "basic");
      run_stream(14'h3FFE, 4, "wrap");

      // Backpressure with a stray descriptor held while busy.
      clear_stats();
      out_ready = 1'b0;
      send_req(14'h1234, 8, e0);
      req_valid = 1'b1;
      req_addr  = 14'h0555;
      req_len   = 7'd3;
      for (int t = 0; t < 6; t++) begin
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      out_ready = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("bp_full_rd_en", 32'(rd_en),     32'd0);
      chk("bp_full_valid", 32'(out_valid), 32'd1);
      chk("bp_full_busy",  32'(busy),      32'd1);
      idle = -1;
      for (int t = 0; t < 300 && idle < 0; t++) begin
         @(posedge clk);
         #1;
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (req_ready) idle = cyc;
      end
      #1;
      chk("bp_idle",    32'(idle >= 0),    32'd1);
      chk("bp_words",   32'(out_words),    32'd8);
      chk("bp_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);
      @(posedge clk);
      #1;

      run_stream(14'h0040, 0, "len0");
      run_stream(14'h0777, 1, "len1");

      // Reset in the middle of a 10-word packet.
      clear_stats();
      out_ready = 1'b1;
      send_req(14'h0800, 10, e0);
      got3 = 0;
      for (int t = 0; t < 50 && got3 == 0; t++) begin
         if (out_words >= 3) got3 = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("mid_three_words", 32'(out_words), 32'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      addr_q.delete();
      exp_q.delete();
      outstanding = 0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_rd_en",     32'(rd_en),     32'd0);
      chk("mid_rst_busy",      32'(busy),      32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      run_stream(14'h2000, 5, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_pkt_reader.md
# sram_pkt_reader

Read-side sequencer for the 16K×16 packet buffer SRAM (1-cycle registered read latency). It accepts a packet descriptor (start address, length in words), issues consecutive SRAM reads and absorbs the read latency in a small credit-controlled buffer. It streams the words downstream on a valid/ready interface with last-word marking, so output backpressure never loses an SRAM read.

## Interface
Parameters:
- `ADDR_W`, 14: SRAM word address width.
- `DATA_W`, 16: SRAM word width.
- `LEN_W`, 7: packet length field width (0..127 words).
- `DEPTH`, 3: read-data buffer entries; also the read credit limit.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: descriptor valid.
- `req_ready` out 1: descriptor accepted when `req_valid && req_ready` at a rising edge.
- `req_addr` in ADDR_W: first word address.
- `req_len` in LEN_W: packet length in words.
- `rd_en` out 1: SRAM read enable.
- `rd_addr` out ADDR_W: SRAM read address.
- `rd_data` in DATA_W: SRAM `dout`, valid the cycle after `rd_en`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out DATA_W: output word.
- `out_last` out 1: final word of the packet, qualified by `out_valid`.
- `busy` out 1: a packet is in progress (state ≠ IDLE).

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On accept, latch `cur_addr`=`req_addr` and `remain`=`req_len`, then go to READ. If `req_len`=0, go to DRAIN instead.
  - READ: issue reads. After the read with `remain`=1 is issued, go to DRAIN.
  - DRAIN: no reads. Go to IDLE at the edge where the buffer is empty and no read is in flight, i.e. after the last word has been handed off, or immediately for a zero-length packet.
- Issue rule (READ only): `rd_en` = `count + inflight < DEPTH`. `count` is the buffer occupancy. `inflight` is `rd_en` registered one cycle. No pop lookahead.
- On each issue: `rd_addr`=`cur_addr`; `cur_addr` increments modulo 2^ADDR_W (0x3FFF wraps to 0x0000); `remain` decrements.
- Capture: when `inflight`=1, push `rd_data` into the buffer together with a last flag. The last flag is set when the read was the packet's final one.
- Output is the buffer head. Pop on `out_valid && out_ready`. `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- Buffer overflow is impossible by construction. Verification asserts `count + inflight <= DEPTH`.
- `req_valid` is ignored outside IDLE, and descriptor fields are sampled only at accept.
- Reset (any time, including mid-packet): state=IDLE, `count`=0, `inflight`=0, `remain`=0, buffer pointers=0. A pending read's data is discarded.
- Reset values of outputs:
  - `req_ready`=1 (first cycle after reset)
  - `rd_en`=0, `rd_addr`=0
  - `out_valid`=0, `out_last`=0, `out_data`=0
  - `busy`=0

## Timing
- Accept at edge E0: `rd_en` high in cycle E0+1 with `rd_addr`=`req_addr`.
- `rd_data` is captured at the end of cycle E0+2, and `out_valid` rises in cycle E0+3.
- With `out_ready` held high, throughput is 1 word/cycle with no bubbles (DEPTH=3 covers issue→capture→pop).
- An N-word packet (N≥1) has its last `out_valid` in cycle E0+N+2, and the FSM is IDLE (`req_ready`=1) in cycle E0+N+3. This is one bubble between packets.
- Zero-length packet: IDLE→DRAIN→IDLE, with `req_ready`=1 again in cycle E0+2. No `rd_en`, no `out_valid`.
- Backpressure: while `count + inflight` = DEPTH, `rd_en` stays low. Issue resumes the cycle after a pop frees a credit.

## Structure
- Shared package `hydra_sram_pkg`:
  - constants `SRAM_ADDR_W`=14, `SRAM_DATA_W`=16
  - typedefs `sram_addr_t`, `sram_data_t`
  - enum `rd_state_t` {IDLE, READ, DRAIN}
- Sub-module `rd_skid_fifo`: DEPTH-entry synchronous FIFO of {last, data}. It has push/pop, a head view, a `count` output, and the same synchronous active-high reset.
- Top level holds the FSM, address/length counters, the `inflight` register and credit logic.

## Test plan
- Reset, then descriptor addr=0x0100, len=4, `out_ready`=1:
  - `rd_addr` 0x0100..0x0103 on consecutive cycles
  - 4 contiguous output words equal to the preloaded SRAM contents, `out_last` on the 4th only
  - `req_ready` back 1 cycle after the last word.
- Wrap: addr=0x3FFE, len=4 → `rd_addr` sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001, with data matching.
- Backpressure: len=8, `out_ready` toggled randomly and held low for 10 cycles → at most 3 reads outstanding, no data loss or duplication, words in order, `out_data` stable while stalled.
- len=0 → no `rd_en`, no `out_valid`, `req_ready` high again 2 cycles after accept; a back-to-back len=1 request is then served correctly.
- `rst` asserted for 1 cycle mid-packet (after 3 of 10 words) → next cycle: `out_valid`=0, `rd_en`=0, `busy`=0, `req_ready`=1; a new packet afterwards streams cleanly with no stale words.
